// File: rtl/yuu_common_rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant, held while the owner keeps requesting.
// Define YUU_COMMON_ARB_WATCHDOG_EN to revoke grants held HOLD_MAX cycles while others wait.
module yuu_common_rr_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 16,
    localparam int ID_W    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy,
    output logic            timeout
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          state;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] win;
    logic            found;
    logic            revoke;
    int              idx;

    if (N < 2 || N > 32 || HOLD_MAX < 2 || HOLD_MAX > 65535) begin : g_bad_param
        $error("yuu_common_rr_arbiter: parameter out of range");
    end

    // First requester after the previous winner, wrapping from N-1 to 0.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[ID_W'(idx)]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

`ifdef YUU_COMMON_ARB_WATCHDOG_EN
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

    logic [15:0] hold_cnt;

    // Cleared while idle so it reads zero in the first owned cycle; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 16'd1;
        end
    end

    assign revoke = (state == OWNED) && (hold_cnt == HOLD_LAST) &&
                    req[gnt_id] && ((req & ~gnt) != '0);
`else
    assign revoke = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            last    <= ID_W'(N - 1);
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt    <= N'(1) << win;
                        gnt_id <= win;
                        last   <= win;
                        busy   <= 1'b1;
                        state  <= OWNED;
                    end
                end
                OWNED: begin
                    if (!req[gnt_id] || revoke) begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        timeout <= revoke;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_yuu_common_rr_arbiter.sv
// Bench for yuu_common_rr_arbiter: directed vector table, watchdog sequence, and
// randomized traffic against a reference model (N=4, HOLD_MAX=4).
module tb_yuu_common_rr_arbiter;
    localparam int N        = 4;
    localparam int HOLD_MAX = 4;
`ifdef YUU_COMMON_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         timeout;

    int total = 0;
    int bad   = 0;

    yuu_common_rr_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int step, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", name, step, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int step, input logic [N-1:0] e_gnt,
                             input logic [1:0] e_id, input logic e_to);
        check({tag, ".gnt"}, step, 32'(gnt), 32'(e_gnt));
        check({tag, ".gnt_id"}, step, 32'(gnt_id), 32'(e_id));
        check({tag, ".busy"}, step, 32'(busy), 32'(e_gnt != '0));
        check({tag, ".timeout"}, step, 32'(timeout), 32'(e_to));
    endtask

    // Drive inputs, take one rising edge, come back to the falling edge to sample.
    task automatic cycle(input logic r, input logic [N-1:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: owner index (-1 when free), previous winner, owned-cycle count.
    int       m_owner;
    int       m_last;
    int       m_id;
    int       m_hold;
    logic     m_to;

    function automatic logic [N-1:0] m_gnt();
        return (m_owner < 0) ? '0 : N'(1 << m_owner);
    endfunction

    task automatic model_step(input logic r, input logic [N-1:0] q);
        bit done;
        m_to = 1'b0;
        if (r) begin
            m_owner = -1;
            m_last  = N - 1;
            m_id    = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            done = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (!done && q[c]) begin
                    done    = 1'b1;
                    m_owner = c;
                    m_last  = c;
                    m_id    = c;
                    m_hold  = 0;
                end
            end
        end else if (!q[m_owner]) begin
            m_owner = -1;
        end else if (WD && m_hold >= HOLD_MAX - 1 && (q & ~N'(1 << m_owner)) != '0) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_hold++;
        end
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic [1:0]   id;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [N-1:0] q, input logic [N-1:0] g,
                       input logic [1:0] i);
        vec_t v;
        v.rst = r; v.req = q; v.gnt = g; v.id = i;
        vecs.push_back(v);
    endtask

    initial begin
        logic [N-1:0] e_gnt;
        logic         e_to;
        logic [N-1:0] q;
        logic         r;

        rst = 1'b1;
        req = '0;

        // Reset held with all requesting, then first grant goes to requester 0.
        add(1, 4'b1111, 4'b0000, 0);
        add(1, 4'b1111, 4'b0000, 0);
        add(1, 4'b1111, 4'b0000, 0);
        add(0, 4'b1111, 4'b0001, 0);
        // Rotation: each owner holds 2 cycles, drops 1 cycle.
        add(0, 4'b1111, 4'b0001, 0);
        add(0, 4'b1110, 4'b0000, 0);
        add(0, 4'b1111, 4'b0010, 1);
        add(0, 4'b1111, 4'b0010, 1);
        add(0, 4'b1101, 4'b0000, 1);
        add(0, 4'b1111, 4'b0100, 2);
        add(0, 4'b1111, 4'b0100, 2);
        add(0, 4'b1011, 4'b0000, 2);
        add(0, 4'b1111, 4'b1000, 3);
        add(0, 4'b1111, 4'b1000, 3);
        add(0, 4'b0111, 4'b0000, 3);
        add(0, 4'b1111, 4'b0001, 0);
        add(0, 4'b0000, 4'b0000, 0);
        // Wrap and skip: make 2 the last winner, then 0011 picks 0 then 1.
        add(0, 4'b0100, 4'b0100, 2);
        add(0, 4'b0000, 4'b0000, 2);
        add(0, 4'b0011, 4'b0001, 0);
        add(0, 4'b0010, 4'b0000, 0);
        add(0, 4'b0010, 4'b0010, 1);
        add(0, 4'b0000, 4'b0000, 1);
        // Sole re-requester regains the grant two cycles after dropping.
        add(0, 4'b0100, 4'b0100, 2);
        add(0, 4'b0000, 4'b0000, 2);
        add(0, 4'b0100, 4'b0100, 2);
        add(0, 4'b0000, 4'b0000, 2);
        // Mid-grant reset with owner 1; afterwards 1 wins since 0 is not requesting.
        add(0, 4'b0010, 4'b0010, 1);
        add(1, 4'b1110, 4'b0000, 0);
        add(0, 4'b1110, 4'b0010, 1);
        add(0, 4'b0000, 4'b0000, 1);

        @(negedge clk);
        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].req);
            check_all("vec", i, vecs[i].gnt, vecs[i].id, 1'b0);
        end

        // Watchdog: last=1, so 0001 grants 0; then 2 also waits while 0 keeps holding.
        cycle(0, 4'b0001);
        check_all("wd", 0, 4'b0001, 0, 1'b0);
        for (int s = 1; s <= 8; s++) begin
            cycle(0, 4'b0101);
            if (WD) begin
                e_gnt = (s <= 3) ? 4'b0001 : (s == 4) ? 4'b0000 : 4'b0100;
                e_to  = (s == 4);
                check_all("wd", s, e_gnt, (s <= 4) ? 2'd0 : 2'd2, e_to);
            end else begin
                check_all("wd", s, 4'b0001, 0, 1'b0);
            end
        end

        // Randomized traffic against the model, starting from reset.
        cycle(1, '0);
        model_step(1, '0);
        check_all("rnd_rst", 0, m_gnt(), 2'(m_id), m_to);
        for (int c = 1; c <= 1500; c++) begin
            for (int i = 0; i < N; i++)
                q[i] = ($urandom_range(0, 99) < ((m_owner == i) ? 88 : 40));
            r = ($urandom_range(0, 249) == 0);
            cycle(r, q);
            model_step(r, q);
            check_all("rnd", c, m_gnt(), 2'(m_id), m_to);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
